// File: rtl/regfile_pkg.sv
// Shared defaults and types for the register file / scoreboard slice.
package regfile_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_PEND_W   = 2;
    localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);

    // Register address and pending-write counter at the default geometry.
    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
    typedef logic [DEF_PEND_W-1:0] pend_cnt_t;

endpackage

// File: rtl/pend_counter.sv
// Saturating outstanding-write counter for one architectural register.
// inc = issue targets this register, dec = writeback retires it, clr = flush.
// busy_next reports whether the counter is non-zero after this cycle.
module pend_counter
    import regfile_pkg::*;
#(
    parameter int PEND_W = DEF_PEND_W
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    input  logic clr,
    output logic busy_next,
    output logic ovf,
    output logic unf
);

    logic [PEND_W-1:0] cnt_reg;
    logic [PEND_W-1:0] cnt_step;
    logic [PEND_W-1:0] cnt_next;

    // Apply issue/retire with saturation at both ends; flush wins over both.
    always_comb begin
        cnt_step = cnt_reg;
        ovf      = 1'b0;
        unf      = 1'b0;
        if (inc && !dec) begin
            if (&cnt_reg) begin
                ovf = 1'b1;
            end else begin
                cnt_step = cnt_reg + PEND_W'(1);
            end
        end else if (dec && !inc) begin
            if (cnt_reg == '0) begin
                unf = 1'b1;
            end else begin
                cnt_step = cnt_reg - PEND_W'(1);
            end
        end
        cnt_next  = clr ? '0 : cnt_step;
        busy_next = |cnt_next;
    end

    // Counter state, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with write-to-read bypass, optional
// hardwired zero register and a per-register outstanding-write scoreboard.
// Busy status is taken from the counters' next state so that an issue shows
// busy, and a retiring writeback shows not-busy, in the same cycle.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NUM_RD   = 2,
    parameter int PEND_W   = DEF_PEND_W,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     flush,
    output logic                     err
);

    logic [DATA_W-1:0]   mem [NUM_REGS];
    logic [NUM_REGS-1:0] busy_next_vec;
    logic [NUM_REGS-1:0] ovf_vec;
    logic [NUM_REGS-1:0] unf_vec;
    logic                wr_ok;
    logic                err_reg;

    // Writes to the hardwired zero register are dropped.
    assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

    // Register storage; reset clears every entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                mem[r] <= '0;
            end
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // One pending-write counter per register; the zero register never counts.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cnt
            localparam logic [ADDR_W-1:0] IDX    = ADDR_W'(gi);
            localparam bit                MASKED = (ZERO_REG != 0) && (gi == 0);

            logic inc;
            logic dec;

            assign inc = !MASKED && iss_en && (iss_addr == IDX);
            assign dec = !MASKED && wr_en  && (wr_addr  == IDX);

            pend_counter #(
                .PEND_W (PEND_W)
            ) u_cnt (
                .clk       (clk),
                .reset     (reset),
                .inc       (inc),
                .dec       (dec),
                .clr       (flush),
                .busy_next (busy_next_vec[gi]),
                .ovf       (ovf_vec[gi]),
                .unf       (unf_vec[gi])
            );
        end
    endgenerate

    // Read ports: bypass the writeback value, force zero for r0 and in reset.
    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic              masked;
            logic [DATA_W-1:0] data;

            assign addr   = rd_addr[gi*ADDR_W +: ADDR_W];
            assign masked = (ZERO_REG != 0) && (addr == '0);

            // Select bypass or stored value for this port.
            always_comb begin
                data = mem[addr];
                if (wr_en && (wr_addr == addr)) begin
                    data = wr_data;
                end
                if (masked || reset) begin
                    data = '0;
                end
            end

            assign rd_data[gi*DATA_W +: DATA_W] = data;
            assign rd_busy[gi] = !reset && !masked && busy_next_vec[addr];
        end
    endgenerate

    // Sticky error: any counter overflow or underflow; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_reg <= 1'b0;
        end else if ((|ovf_vec) || (|unf_vec)) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus a
// randomized run against an array/integer reference model.
module tb_regfile_scoreboard;
    import regfile_pkg::*;

    localparam int DW   = 32;
    localparam int NR   = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;
    localparam int PW   = 2;
    localparam int CMAX = (1 << PW) - 1;

    logic                  clk;
    logic                  reset;
    logic [NRD*AW-1:0]     rd_addr;
    logic [NRD*DW-1:0]     rd_data;
    logic [NRD-1:0]        rd_busy;
    logic                  wr_en;
    reg_addr_t             wr_addr;
    logic [DW-1:0]         wr_data;
    logic                  iss_en;
    reg_addr_t             iss_addr;
    logic                  flush;
    logic                  err;

    // Reference model state
    logic [DW-1:0] m_mem [NR];
    int            m_cnt [NR];
    bit            m_err;

    int errors = 0;
    int checks = 0;

    regfile_scoreboard #(
        .DATA_W   (DW),
        .NUM_REGS (NR),
        .NUM_RD   (NRD),
        .PEND_W   (PW),
        .ZERO_REG (1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Next pending count of register r given the inputs currently driven.
    function automatic int nxt_cnt(input int r, output bit e);
        bit inc;
        bit dec;
        int n;
        inc = iss_en && (int'(iss_addr) == r) && (r != 0);
        dec = wr_en  && (int'(wr_addr)  == r) && (r != 0);
        e   = 1'b0;
        n   = m_cnt[r];
        if (inc && !dec) begin
            if (n == CMAX) e = 1'b1;
            else           n = n + 1;
        end else if (dec && !inc) begin
            if (n == 0) e = 1'b1;
            else        n = n - 1;
        end
        if (flush) n = 0;
        return n;
    endfunction

    function automatic logic [DW-1:0] exp_data(input int a);
        if (reset || a == 0) return '0;
        if (wr_en && int'(wr_addr) == a) return wr_data;
        return m_mem[a];
    endfunction

    function automatic bit exp_busy(input int a);
        bit e;
        if (reset || a == 0) return 1'b0;
        return nxt_cnt(a, e) != 0;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < NR; r++) begin
            m_mem[r] = '0;
            m_cnt[r] = 0;
        end
        m_err = 1'b0;
    endtask

    // Drive one cycle's inputs after the falling edge.
    task automatic apply(input bit rst, input bit ie, input int ia,
                         input bit we, input int wa, input logic [DW-1:0] wd,
                         input bit fl, input int a0, input int a1);
        @(negedge clk);
        reset    = rst;
        iss_en   = ie;
        iss_addr = reg_addr_t'(ia);
        wr_en    = we;
        wr_addr  = reg_addr_t'(wa);
        wr_data  = wd;
        flush    = fl;
        rd_addr  = {reg_addr_t'(a1), reg_addr_t'(a0)};
        if (rst) model_clear();
        #1;
    endtask

    // Advance through the rising edge and update the model.
    task automatic tick();
        bit e;
        @(posedge clk);
        if (!reset) begin
            for (int r = 0; r < NR; r++) begin
                m_cnt[r] = nxt_cnt(r, e);
                if (e) m_err = 1'b1;
            end
            if (wr_en && wr_addr != 0) m_mem[wr_addr] = wr_data;
        end
        $display("t=%0t rst=%0b iss=%0b/%0d wr=%0b/%0d/%h fl=%0b ra=%0d,%0d busy=%b err=%0b",
                 $time, reset, iss_en, iss_addr, wr_en, wr_addr, wr_data, flush,
                 rd_addr[AW-1:0], rd_addr[2*AW-1:AW], rd_busy, err);
        #1;
    endtask

    task automatic test_reset();
        apply(1, 0, 0, 1, 0, 32'hDEADBEEF, 0, 0, 0);
        checks++;
        if (rd_data !== '0 || rd_busy !== '0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: data=%h busy=%b err=%b, want 0/0/0", rd_data, rd_busy, err);
        end
        tick();
        apply(0, 0, 0, 1, 0, 32'hDEADBEEF, 0, 0, 0);
        checks++;
        if (rd_data[31:0] !== 32'h0 || rd_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL zero_reg_write: data=%h busy=%b, want 0/0", rd_data[31:0], rd_busy[0]);
        end
        tick();
        for (int i = 0; i < NR / 2; i++) begin
            apply(0, 0, 0, 0, 0, 0, 0, 2 * i, 2 * i + 1);
            checks++;
            if (rd_data !== '0 || rd_busy !== '0) begin
                errors++;
                $display("FAIL reset_read r%0d/r%0d: data=%h busy=%b, want 0", 2 * i, 2 * i + 1, rd_data, rd_busy);
            end
            tick();
        end
    endtask

    task automatic test_bypass();
        apply(0, 0, 0, 1, 5, 32'h1234, 0, 5, 5);
        checks++;
        if (rd_data[31:0] !== 32'h1234 || rd_data[63:32] !== 32'h1234) begin
            errors++;
            $display("FAIL bypass_same_cycle: data=%h, want both 00001234", rd_data);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 0, 0, 0, 0, 5, 0);
            checks++;
            if (rd_data[31:0] !== 32'h1234) begin
                errors++;
                $display("FAIL bypass_stored: data=%h, want 00001234", rd_data[31:0]);
            end
            tick();
        end
    endtask

    task automatic test_scoreboard();
        for (int i = 0; i < 2; i++) begin
            apply(0, 1, 7, 0, 0, 0, 0, 7, 7);
            checks++;
            if (rd_busy !== 2'b11) begin
                errors++;
                $display("FAIL sb_issue%0d: busy=%b, want 11", i, rd_busy);
            end
            tick();
        end
        apply(0, 0, 0, 1, 7, 32'hAAAA0001, 0, 7, 0);
        checks++;
        if (rd_busy[0] !== 1'b1 || rd_data[31:0] !== 32'hAAAA0001) begin
            errors++;
            $display("FAIL sb_first_wb: busy=%b data=%h, want 1/aaaa0001", rd_busy[0], rd_data[31:0]);
        end
        tick();
        apply(0, 0, 0, 1, 7, 32'hAAAA0002, 0, 7, 7);
        checks++;
        if (rd_busy !== 2'b00 || rd_data[63:32] !== 32'hAAAA0002) begin
            errors++;
            $display("FAIL sb_last_wb: busy=%b data=%h, want 00/aaaa0002", rd_busy, rd_data[63:32]);
        end
        tick();
    endtask

    task automatic test_simultaneous();
        apply(0, 1, 9, 0, 0, 0, 0, 9, 0);
        tick();
        apply(0, 1, 9, 1, 9, 32'hC0DE0009, 0, 9, 0);
        checks++;
        if (rd_busy[0] !== 1'b1 || rd_data[31:0] !== 32'hC0DE0009) begin
            errors++;
            $display("FAIL simul_iss_wb: busy=%b data=%h, want 1/c0de0009", rd_busy[0], rd_data[31:0]);
        end
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 9, 0);
        checks++;
        if (rd_busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL simul_hold: busy=%b, want 1", rd_busy[0]);
        end
        tick();
        apply(0, 0, 0, 1, 9, 32'h9, 0, 9, 0);
        checks++;
        if (rd_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL simul_drain: busy=%b, want 0", rd_busy[0]);
        end
        tick();
    endtask

    task automatic test_saturation();
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            apply(0, 1, 3, 0, 0, 0, 0, 3, 0);
            checks++;
            if (err !== 1'b0 || rd_busy[0] !== 1'b1) begin
                errors++;
                $display("FAIL sat_issue%0d: err=%b busy=%b, want 0/1", i, err, rd_busy[0]);
            end
            tick();
        end
        apply(0, 0, 0, 1, 4, 32'h44444444, 0, 3, 4);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL sat_overflow_err: err=%b, want 1", err);
        end
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 4, 0);
        checks++;
        if (rd_data[31:0] !== 32'h44444444 || err !== 1'b1) begin
            errors++;
            $display("FAIL sat_unpended_write: data=%h err=%b, want 44444444/1", rd_data[31:0], err);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 1, 3, 32'h30 + i, 0, 3, 0);
            checks++;
            if (rd_busy[0] !== (i < 2)) begin
                errors++;
                $display("FAIL sat_drain%0d: busy=%b, want %0b", i, rd_busy[0], (i < 2));
            end
            tick();
        end
    endtask

    task automatic test_underflow();
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        apply(0, 0, 0, 1, 4, 32'hF00D0004, 0, 4, 0);
        checks++;
        if (err !== 1'b0 || rd_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL unf_before: err=%b busy=%b, want 0/0", err, rd_busy[0]);
        end
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 4, 0);
        checks++;
        if (err !== 1'b1 || rd_data[31:0] !== 32'hF00D0004) begin
            errors++;
            $display("FAIL unf_after: err=%b data=%h, want 1/f00d0004", err, rd_data[31:0]);
        end
        tick();
    endtask

    task automatic test_flush();
        apply(0, 0, 0, 1, 1, 32'h11111111, 0, 0, 0);
        tick();
        apply(0, 0, 0, 1, 2, 32'h22222222, 0, 0, 0);
        tick();
        apply(0, 1, 1, 0, 0, 0, 0, 1, 2);
        tick();
        apply(0, 1, 2, 0, 0, 0, 0, 1, 2);
        checks++;
        if (rd_busy !== 2'b11) begin
            errors++;
            $display("FAIL flush_pending: busy=%b, want 11", rd_busy);
        end
        tick();
        apply(0, 0, 0, 0, 0, 0, 1, 1, 2);
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 1, 2);
        checks++;
        if (rd_busy !== 2'b00 || rd_data !== {32'h22222222, 32'h11111111}) begin
            errors++;
            $display("FAIL flush_after: busy=%b data=%h, want 00/2222222211111111", rd_busy, rd_data);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        apply(0, 0, 0, 1, 6, 32'h66666666, 0, 6, 0);
        tick();
        apply(1, 1, 6, 1, 6, 32'h77777777, 0, 6, 0);
        checks++;
        if (rd_data[31:0] !== 32'h0 || rd_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_during: data=%h busy=%b, want 0/0", rd_data[31:0], rd_busy[0]);
        end
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 6, 0);
        checks++;
        if (rd_data[31:0] !== 32'h0 || rd_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_after: data=%h busy=%b, want 0/0", rd_data[31:0], rd_busy[0]);
        end
        tick();
    endtask

    task automatic test_random();
        int a0;
        int a1;
        for (int i = 0; i < 400; i++) begin
            a0 = int'($urandom_range(0, 7));
            a1 = int'($urandom_range(0, 7));
            apply(($urandom % 64) == 0, $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
                  $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)), $urandom,
                  ($urandom % 32) == 0, a0, a1);
            checks++;
            if (rd_data[31:0] !== exp_data(a0) || rd_data[63:32] !== exp_data(a1)) begin
                errors++;
                $display("FAIL rand_data #%0d: got %h, want %h%h", i, rd_data, exp_data(a1), exp_data(a0));
            end
            checks++;
            if (rd_busy[0] !== exp_busy(a0) || rd_busy[1] !== exp_busy(a1)) begin
                errors++;
                $display("FAIL rand_busy #%0d: got %b, want %b%b", i, rd_busy, exp_busy(a1), exp_busy(a0));
            end
            checks++;
            if (err !== m_err) begin
                errors++;
                $display("FAIL rand_err #%0d: got %b, want %b", i, err, m_err);
            end
            tick();
        end
    endtask

    initial begin
        reset    = 1'b1;
        iss_en   = 1'b0;
        iss_addr = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        flush    = 1'b0;
        rd_addr  = '0;
        model_clear();
        test_reset();
        test_bypass();
        test_scoreboard();
        test_simultaneous();
        test_saturation();
        test_underflow();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised multi-read-port register file for the pipelined MIPS datapath. It adds three things to a plain register file: same-cycle write-to-read bypass, a hardwired zero register, and a per-register outstanding-write scoreboard. Decode reads operands and busy status here. Issue marks destination registers pending, and writeback retires them. The hazard unit uses the `rd_busy` outputs to generate stalls.

## Interface
Parameters:
- `DATA_W`, 32, register width in bits
- `NUM_REGS`, 32, number of architectural registers
- `ADDR_W`, `$clog2(NUM_REGS)`, register address width (derived)
- `NUM_RD`, 2, number of read ports, range 1–4
- `PEND_W`, 2, width of each outstanding-write counter
- `ZERO_REG`, 1, when 1, register 0 reads as 0 and is never busy

Ports:
- `clk` in 1: rising-edge clock
- `reset` in 1: reset, asynchronous, active-high
- `rd_addr` in `NUM_RD*ADDR_W`: packed read addresses; port k occupies bits `[k*ADDR_W +: ADDR_W]`
- `rd_data` out `NUM_RD*DATA_W`: packed read data, with bypass applied
- `rd_busy` out `NUM_RD`: the addressed register still has an outstanding write after this cycle's writeback
- `wr_en` in 1: writeback strobe
- `wr_addr` in `ADDR_W`: writeback register
- `wr_data` in `DATA_W`: writeback value
- `iss_en` in 1: issue strobe; marks `iss_addr` pending
- `iss_addr` in `ADDR_W`: destination of the issued instruction
- `flush` in 1: synchronous clear of all pending counters
- `err` out 1: sticky error, set on counter overflow or underflow

## Operation
- **Storage:** `NUM_REGS` × `DATA_W` array. Write on the rising edge when `wr_en` is high.
- **Zero register:** with `ZERO_REG`=1, writes and issues to address 0 are ignored. `rd_data` for address 0 is 0 and `rd_busy` is 0.
- **Read path (combinational):** if `wr_en` and `wr_addr`==`rd_addr[k]` (and the address is not zero-masked), `rd_data[k]`=`wr_data`. Otherwise it is the stored value.
- **Pending counter per register, `cnt[r]`:**
  - `iss_en` only: `cnt`+1
  - `wr_en` only: `cnt`−1
  - both on the same r: unchanged
- **Overflow:** increment when `cnt`=all-ones leaves `cnt` unchanged and sets `err`.
- **Underflow:** decrement when `cnt`=0 leaves `cnt` at 0 and sets `err`. Writes with no pending issue are still performed.
- **Busy output:** `rd_busy[k]` = (next-state `cnt[rd_addr[k]]` != 0). Next-state includes this cycle's issue and writeback, so a retiring write shows not-busy in the same cycle, and its data is bypassed.
- **Flush:** all `cnt` go to 0 at the next edge; register contents are unchanged. Issue and writeback in the flush cycle still update storage, but every counter ends at 0. `flush` has no effect on `err`.
- **`err` clear:** only `reset` clears `err`.

## Timing
- **Reset (asynchronous):** all registers 0, all `cnt` 0, `err` 0. Consequently `rd_data` is 0 and `rd_busy` is 0 immediately.
- **Reset mid-operation:** reset overrides everything in the same cycle. No write in that cycle survives.
- **Read latency:** 0 cycles (combinational from `rd_addr`, `wr_*`, `iss_*`).
- **Write latency:** the value is visible through bypass in the same cycle and through storage from the next cycle.
- **Issue latency:** `rd_busy` reflects an issue in the same cycle, because it is derived from next-state.
- **Simultaneous writeback on two read ports:** both ports see the bypass independently.

## Structure
- **Package `regfile_pkg`:**
  - default `DATA_W`, `NUM_REGS` and `PEND_W` constants
  - a `reg_addr_t` typedef
  - a `pend_cnt_t` typedef
- **Sub-module `pend_counter`:**
  - one per register
  - inputs: `inc`, `dec`, `clr`
  - outputs: `busy_next`, `ovf`, `unf`
  - implements the saturation rules
- **Top level:**
  - storage array
  - bypass muxes, via a generate loop over `NUM_RD`
  - `err` OR-reduction

## Test plan
- **Reset and zero register:** assert reset, then write 0xDEADBEEF to r0. Expect `rd_data`(r0)=0 and `rd_busy`=0; every register reads 0 after reset.
- **Bypass:** `wr_en`, r5, 0x1234 with `rd_addr0`=r5 in the same cycle. Expect `rd_data0`=0x1234 that cycle and on every following cycle.
- **Scoreboard:**
  - issue r7 twice (cycles 1 and 2) → `rd_busy`=1
  - first writeback of r7 → still busy
  - second writeback → `rd_busy`=0 in that same cycle
- **Simultaneous issue and writeback:** on r9 with `cnt`=1 → `cnt` stays 1 and `rd_busy`=1.
- **Saturation:** with `PEND_W`=2, four issues to r3 → `err`=1 and `cnt`=3. Writeback to r4 with `cnt`=0 → data written and `err` stays 1.
- **Flush and reset mid-operation:**
  - r1 and r2 pending, then `flush` → `rd_busy`=0 next cycle, contents kept
  - `reset` asserted together with `wr_en` → r-value 0
